// File: rtl/serial_comparator_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
// The master side drives the operands; the slave side (the comparator) returns status and result flags.
interface serial_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, signed_mode, x, y,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, signed_mode, x, y,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial comparator: scans captured operands one bit pair per cycle, MSB first, and stops at the first difference.
// In signed mode, a difference in the sign bit reverses which operand counts as greater.
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comparator_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t           state_r,  state_s;
    logic [WIDTH-1:0] x_r,      x_s;
    logic [WIDTH-1:0] y_r,      y_s;
    logic             signed_r, signed_s;
    logic [IDX_W-1:0] idx_r,    idx_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic             eq_r,     eq_s;
    logic             gt_r,     gt_s;
    logic             lt_r,     lt_s;
    logic             bit_x_s;
    logic             bit_y_s;
    logic             sign_flip_s;

    // Next-state and next-output logic for the IDLE/CMP controller
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        signed_s    = signed_r;
        idx_s       = idx_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        eq_s        = eq_r;
        gt_s        = gt_r;
        lt_s        = lt_r;
        bit_x_s     = x_r[idx_r];
        bit_y_s     = y_r[idx_r];
        sign_flip_s = signed_r && (idx_r == IDX_MSB);

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    x_s      = bus.x;
                    y_s      = bus.y;
                    signed_s = bus.signed_mode;
                    idx_s    = IDX_MSB;
                    busy_s   = 1'b1;
                    state_s  = ST_CMP;
                end else begin
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (bit_x_s != bit_y_s) begin
                    // A 1 in the sign bit marks the negative (smaller) operand
                    gt_s    = sign_flip_s ? bit_y_s : bit_x_s;
                    lt_s    = sign_flip_s ? bit_x_s : bit_y_s;
                    eq_s    = 1'b0;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (idx_r == {IDX_W{1'b0}}) begin
                    eq_s    = 1'b1;
                    gt_s    = 1'b0;
                    lt_s    = 1'b0;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    idx_s   = idx_r - IDX_W'(1);
                    state_s = ST_CMP;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured operands and registered result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            x_r      <= {WIDTH{1'b0}};
            y_r      <= {WIDTH{1'b0}};
            signed_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            x_r      <= x_s;
            y_r      <= y_s;
            signed_r <= signed_s;
            idx_r    <= idx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            eq_r     <= eq_s;
            gt_r     <= gt_s;
            lt_r     <= lt_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.eq   = eq_r;
    assign bus.gt   = gt_r;
    assign bus.lt   = lt_r;
endmodule
